// File: rtl/romix_job_scheduler_if.sv
// ---------------------------------------------------------------------------
// romix_job_scheduler_if
//  Host-side handshake bundle of the ROMix job scheduler.
//  Job port   : job_valid / job_ready / job_id       (host -> scheduler)
//  Result port: res_valid / res_ready / res_id / res_core (scheduler -> host)
//  Modports:
//   master - host side (offers jobs, consumes results)
//   slave  - scheduler side
// ---------------------------------------------------------------------------
interface romix_job_scheduler_if #(
   parameter int ID_W   = 8,
   parameter int CORE_W = 2
);
   logic              job_valid;
   logic              job_ready;
   logic [ID_W-1:0]   job_id;
   logic              res_valid;
   logic              res_ready;
   logic [ID_W-1:0]   res_id;
   logic [CORE_W-1:0] res_core;

   modport master (
      output job_valid, job_id, res_ready,
      input  job_ready, res_valid, res_id, res_core
   );

   modport slave (
      input  job_valid, job_id, res_ready,
      output job_ready, res_valid, res_id, res_core
   );
endinterface

// File: rtl/romix_job_scheduler.sv
// ---------------------------------------------------------------------------
// romix_job_scheduler
//  Dispatches scrypt ROMix jobs to NUM_CORES init/valid controlled cores and
//  collects their completions onto one valid/ready result port.
//  Each core walks C_IDLE -> C_RUN -> C_HOLD -> C_RELEASE -> C_IDLE.
//  Jobs go to the first idle core at or after disp_ptr; results are taken
//  from the first holding core at or after res_ptr (both round-robin).
//
//  Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   bus          romix_job_scheduler_if.slave (job and result handshakes)
//   core_init    per-core init, registered
//   core_valid   per-core done, held high while init is high
//   busy         any core not in C_IDLE
//   timeout_err  sticky per-core watchdog flags
//
//  Optional feature: define ROMIX_SCHED_TIMEOUT_EN to enable a per-core
//  watchdog of TIMEOUT_CYCLES run cycles. Without it timeout_err is 0 and a
//  core may run indefinitely.
// ---------------------------------------------------------------------------
module romix_job_scheduler #(
   parameter int NUM_CORES      = 4,
   parameter int ID_W           = 8,
   parameter int CORE_W         = 2,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic                   clk,
   input  logic                   reset,
   romix_job_scheduler_if.slave   bus,
   output logic [NUM_CORES-1:0]   core_init,
   input  logic [NUM_CORES-1:0]   core_valid,
   output logic                   busy,
   output logic [NUM_CORES-1:0]   timeout_err
);

   if (NUM_CORES < 1 || NUM_CORES > 16 || (1 << CORE_W) < NUM_CORES || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("romix_job_scheduler: illegal parameter combination");
   end

   typedef enum logic [1:0] {C_IDLE, C_RUN, C_HOLD, C_RELEASE} core_state_t;

   core_state_t       state_q [NUM_CORES];
   core_state_t       state_d [NUM_CORES];
   logic [ID_W-1:0]   tag_q   [NUM_CORES];
   logic [ID_W-1:0]   tag_d   [NUM_CORES];
   logic              init_q  [NUM_CORES];
   logic              init_d  [NUM_CORES];

   logic [NUM_CORES-1:0] idle_vec;
   logic [NUM_CORES-1:0] hold_vec;

   logic [CORE_W-1:0] disp_ptr_q, disp_ptr_d;
   logic [CORE_W-1:0] res_ptr_q, res_ptr_d;
   logic              lock_q, lock_d;
   logic [CORE_W-1:0] lock_idx_q, lock_idx_d;

   logic [CORE_W:0]   disp_pick;
   logic [CORE_W:0]   res_pick;
   logic [CORE_W-1:0] disp_gnt;
   logic [CORE_W-1:0] res_gnt;
   logic              accept;
   logic              xfer;

   // Round-robin search: returns {found, index} of the first set request at
   // or after ptr. Iterating from the far end lets the nearest hit win.
   function automatic logic [CORE_W:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                               input logic [CORE_W-1:0]   ptr);
      logic [CORE_W:0] r;
      int              idx;
      r = '0;
      for (int off = NUM_CORES - 1; off >= 0; off--) begin
         idx = int'(ptr) + off;
         if (idx >= NUM_CORES) idx = idx - NUM_CORES;
         if (req[idx]) r = {1'b1, CORE_W'(idx)};
      end
      return r;
   endfunction

   function automatic logic [CORE_W-1:0] wrap_inc(input logic [CORE_W-1:0] p);
      return (int'(p) == NUM_CORES - 1) ? '0 : p + 1'b1;
   endfunction

   // ---------------- dispatch / result arbitration ----------------
   assign disp_pick     = rr_pick(idle_vec, disp_ptr_q);
   assign res_pick      = rr_pick(hold_vec, res_ptr_q);
   assign disp_gnt      = disp_pick[CORE_W-1:0];
   assign bus.job_ready = disp_pick[CORE_W];
   assign bus.res_valid = res_pick[CORE_W];
   // A stalled result keeps its core even if an earlier-ranked core joins C_HOLD.
   assign res_gnt       = lock_q ? lock_idx_q : res_pick[CORE_W-1:0];
   assign bus.res_core  = bus.res_valid ? res_gnt : '0;
   assign bus.res_id    = bus.res_valid ? tag_q[res_gnt] : '0;
   assign accept        = bus.job_valid && bus.job_ready;
   assign xfer          = bus.res_valid && bus.res_ready;
   assign busy          = ~&idle_vec;

   always_comb begin
      disp_ptr_d = disp_ptr_q;
      res_ptr_d  = res_ptr_q;
      lock_d     = bus.res_valid && !bus.res_ready;
      lock_idx_d = res_gnt;
      if (accept) disp_ptr_d = wrap_inc(disp_gnt);
      if (xfer)   res_ptr_d  = wrap_inc(res_gnt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         disp_ptr_q <= '0;
         res_ptr_q  <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         disp_ptr_q <= disp_ptr_d;
         res_ptr_q  <= res_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   // ---------------- per-core state machines ----------------
   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      logic to_fire;

`ifdef ROMIX_SCHED_TIMEOUT_EN
      localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
      logic [TO_W-1:0] cnt_q, cnt_d;
      logic            err_q, err_d;

      // Counter is zeroed on dispatch and advances once per C_RUN cycle.
      assign to_fire = (state_q[gi] == C_RUN) && !core_valid[gi] &&
                       (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

      always_comb begin
         cnt_d = cnt_q;
         err_d = err_q | to_fire;
         if (state_q[gi] == C_IDLE) cnt_d = '0;
         else if (state_q[gi] == C_RUN && !to_fire) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
         end
      end

      assign timeout_err[gi] = err_q;
`else
      assign to_fire         = 1'b0;
      assign timeout_err[gi] = 1'b0;
`endif

      assign idle_vec[gi]  = (state_q[gi] == C_IDLE);
      assign hold_vec[gi]  = (state_q[gi] == C_HOLD);
      assign core_init[gi] = init_q[gi];

      always_comb begin
         state_d[gi] = state_q[gi];
         tag_d[gi]   = tag_q[gi];
         init_d[gi]  = init_q[gi];
         case (state_q[gi])
            C_IDLE: begin
               if (accept && disp_gnt == CORE_W'(gi)) begin
                  state_d[gi] = C_RUN;
                  tag_d[gi]   = bus.job_id;
                  init_d[gi]  = 1'b1;
               end
            end
            C_RUN: begin
               if (core_valid[gi]) begin
                  state_d[gi] = C_HOLD;
               end else if (to_fire) begin
                  state_d[gi] = C_RELEASE;
                  init_d[gi]  = 1'b0;
               end
            end
            C_HOLD: begin
               if (xfer && res_gnt == CORE_W'(gi)) begin
                  state_d[gi] = C_RELEASE;
                  init_d[gi]  = 1'b0;
               end
            end
            C_RELEASE: begin
               // Wait for the core to acknowledge init low before reuse.
               if (!core_valid[gi]) state_d[gi] = C_IDLE;
            end
            default: state_d[gi] = C_IDLE;
         endcase
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q[gi] <= C_IDLE;
            tag_q[gi]   <= '0;
            init_q[gi]  <= 1'b0;
         end else begin
            state_q[gi] <= state_d[gi];
            tag_q[gi]   <= tag_d[gi];
            init_q[gi]  <= init_d[gi];
         end
      end
   end

endmodule

// File: tb/tb_romix_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_romix_job_scheduler
//  Directed bench for romix_job_scheduler with NUM_CORES=4, ID_W=8.
//  Inputs change 1 time unit after the rising edge; outputs are checked at
//  that same point, away from the edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_romix_job_scheduler;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] core_init;
   logic [3:0] core_valid;
   logic       busy;
   logic [3:0] timeout_err;

   int tests = 0;
   int fails = 0;

   romix_job_scheduler_if #(.ID_W(8), .CORE_W(2)) bus ();

   romix_job_scheduler #(
      .NUM_CORES(4), .ID_W(8), .CORE_W(2), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave),
      .core_init(core_init), .core_valid(core_valid),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.job_valid = 1'b0;
      bus.job_id = 8'h00;
      bus.res_ready = 1'b0;
      core_valid = 4'b0000;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (core_init !== 4'b0000) begin fails++; $display("FAIL reset_init: got %b expected 0000", core_init); end
      tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (bus.res_id !== 8'h00 || bus.res_core !== 2'd0) begin fails++; $display("FAIL reset_res_bus: got id %h core %0d expected 00/0", bus.res_id, bus.res_core); end
      tests++; if (bus.job_ready !== 1'b1) begin fails++; $display("FAIL reset_job_ready: got %b expected 1", bus.job_ready); end
      tests++; if (timeout_err !== 4'b0000) begin fails++; $display("FAIL reset_timeout: got %b expected 0000", timeout_err); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_single();
      do_reset();
      bus.job_valid = 1'b1; bus.job_id = 8'h5A;
      step();
      bus.job_valid = 1'b0;
      tests++; if (core_init !== 4'b0001) begin fails++; $display("FAIL single_init: got %b expected 0001", core_init); end
      for (int i = 0; i < 5; i++) step();
      tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL single_early_res: got %b expected 0", bus.res_valid); end
      core_valid[0] = 1'b1;
      step();
      tests++; if (bus.res_valid !== 1'b1 || bus.res_id !== 8'h5A || bus.res_core !== 2'd0)
         begin fails++; $display("FAIL single_result: got v%b id %h core %0d expected v1 id 5a core 0", bus.res_valid, bus.res_id, bus.res_core); end
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      tests++; if (core_init !== 4'b0000 || bus.res_valid !== 1'b0) begin fails++; $display("FAIL single_release: got init %b v%b expected 0000 v0", core_init, bus.res_valid); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_release: got %b expected 1", busy); end
      core_valid[0] = 1'b0;
      step();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: got busy %b expected 0", busy); end
      $display("[TB] test_single done");
   endtask

   task automatic test_fill();
      logic [3:0] exp_init;
      do_reset();
      bus.job_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.job_id = 8'(k + 1);
         step();
         exp_init = 4'((1 << (k + 1)) - 1);
         tests++; if (core_init !== exp_init) begin fails++; $display("FAIL fill_grant%0d: got %b expected %b", k, core_init, exp_init); end
      end
      bus.job_id = 8'h05;
      tests++; if (bus.job_ready !== 1'b0) begin fails++; $display("FAIL fill_full_ready: got %b expected 0", bus.job_ready); end
      step(); step();
      tests++; if (core_init !== 4'b1111) begin fails++; $display("FAIL fill_held: got %b expected 1111", core_init); end
      core_valid[2] = 1'b1;
      step();
      tests++; if (bus.res_core !== 2'd2 || bus.res_id !== 8'h03) begin fails++; $display("FAIL fill_res2: got core %0d id %h expected 2/03", bus.res_core, bus.res_id); end
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      tests++; if (core_init !== 4'b1011 || bus.job_ready !== 1'b0) begin fails++; $display("FAIL fill_release: got init %b rdy %b expected 1011 0", core_init, bus.job_ready); end
      core_valid[2] = 1'b0;
      step();
      tests++; if (bus.job_ready !== 1'b1) begin fails++; $display("FAIL fill_freed_ready: got %b expected 1", bus.job_ready); end
      step();
      bus.job_valid = 1'b0;
      tests++; if (core_init !== 4'b1111) begin fails++; $display("FAIL fill_job5: got %b expected 1111", core_init); end
      core_valid[2] = 1'b1;
      step();
      tests++; if (bus.res_core !== 2'd2 || bus.res_id !== 8'h05) begin fails++; $display("FAIL fill_job5_tag: got core %0d id %h expected 2/05", bus.res_core, bus.res_id); end
      $display("[TB] test_fill done");
   endtask

   task automatic test_backpressure();
      int held_bad;
      do_reset();
      bus.job_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.job_id = 8'(8'h10 + k);
         step();
      end
      bus.job_valid = 1'b0;
      core_valid[1] = 1'b1; core_valid[3] = 1'b1;
      step();
      held_bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (c == 3) core_valid[0] = 1'b1;  // earlier-ranked core joins while stalled
         if (bus.res_valid !== 1'b1 || bus.res_core !== 2'd1 || bus.res_id !== 8'h11) held_bad++;
         step();
      end
      tests++; if (held_bad != 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles (now core %0d id %h) expected 0", held_bad, bus.res_core, bus.res_id); end
      bus.res_ready = 1'b1;
      tests++; if (bus.res_core !== 2'd1) begin fails++; $display("FAIL bp_first: got core %0d expected 1", bus.res_core); end
      step();
      tests++; if (bus.res_core !== 2'd3 || bus.res_id !== 8'h13) begin fails++; $display("FAIL bp_second: got core %0d id %h expected 3/13", bus.res_core, bus.res_id); end
      step();
      tests++; if (bus.res_core !== 2'd0 || bus.res_id !== 8'h10) begin fails++; $display("FAIL bp_third: got core %0d id %h expected 0/10", bus.res_core, bus.res_id); end
      step();
      bus.res_ready = 1'b0;
      tests++; if (bus.res_valid !== 1'b0 || core_init !== 4'b0100) begin fails++; $display("FAIL bp_drained: got v%b init %b expected v0 0100", bus.res_valid, core_init); end
      $display("[TB] test_backpressure done");
   endtask

   task automatic test_same_cycle();
      do_reset();
      bus.job_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.job_id = 8'(8'hA0 + k);
         step();
      end
      bus.job_valid = 1'b0;
      core_valid[2] = 1'b1;
      step();
      tests++; if (bus.res_core !== 2'd2 || bus.res_id !== 8'hA2) begin fails++; $display("FAIL same_res2: got core %0d id %h expected 2/a2", bus.res_core, bus.res_id); end
      bus.job_valid = 1'b1; bus.job_id = 8'h77; bus.res_ready = 1'b1;
      step();
      bus.job_valid = 1'b0; bus.res_ready = 1'b0;
      tests++; if (core_init !== 4'b1011) begin fails++; $display("FAIL same_both: got init %b expected 1011", core_init); end
      tests++; if (bus.job_ready !== 1'b0) begin fails++; $display("FAIL same_release_not_free: got %b expected 0", bus.job_ready); end
      core_valid[2] = 1'b0; core_valid[3] = 1'b1;
      step();
      tests++; if (bus.res_core !== 2'd3 || bus.res_id !== 8'h77) begin fails++; $display("FAIL same_tag77: got core %0d id %h expected 3/77", bus.res_core, bus.res_id); end
      tests++; if (bus.job_ready !== 1'b1) begin fails++; $display("FAIL same_core2_free: got %b expected 1", bus.job_ready); end
      $display("[TB] test_same_cycle done");
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.job_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.job_id = 8'(8'h30 + k);
         step();
      end
      bus.job_valid = 1'b0;
      tests++; if (core_init !== 4'b0111) begin fails++; $display("FAIL mid_running: got %b expected 0111", core_init); end
      reset = 1'b1;
      step();
      tests++; if (core_init !== 4'b0000 || bus.res_valid !== 1'b0 || busy !== 1'b0)
         begin fails++; $display("FAIL mid_reset: got init %b v%b busy %b expected 0000 0 0", core_init, bus.res_valid, busy); end
      reset = 1'b0;
      bus.job_valid = 1'b1; bus.job_id = 8'h99;
      step();
      bus.job_valid = 1'b0;
      tests++; if (core_init !== 4'b0001) begin fails++; $display("FAIL mid_first_job: got %b expected 0001", core_init); end
      $display("[TB] test_reset_mid done");
   endtask

   task automatic test_ignore_idle_valid();
      do_reset();
      core_valid = 4'b0010;
      step(); step();
      tests++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL ignore_idle: got v%b busy %b expected 0 0", bus.res_valid, busy); end
      core_valid = 4'b0000;
      $display("[TB] test_ignore_idle_valid done");
   endtask

`ifdef ROMIX_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      bus.job_valid = 1'b1; bus.job_id = 8'hEE;
      step();
      bus.job_valid = 1'b0;
      for (int c = 0; c < 63; c++) step();
      tests++; if (timeout_err !== 4'b0000 || core_init !== 4'b0001) begin fails++; $display("FAIL to_early: got err %b init %b expected 0000 0001", timeout_err, core_init); end
      step();
      tests++; if (timeout_err !== 4'b0001 || core_init !== 4'b0000 || bus.res_valid !== 1'b0)
         begin fails++; $display("FAIL to_fire: got err %b init %b v%b expected 0001 0000 0", timeout_err, core_init, bus.res_valid); end
      step(); step();
      tests++; if (timeout_err !== 4'b0001 || busy !== 1'b0) begin fails++; $display("FAIL to_sticky: got err %b busy %b expected 0001 0", timeout_err, busy); end
      $display("[TB] test_timeout done");
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_backpressure();
      test_same_cycle();
      test_reset_mid();
      test_ignore_idle_valid();
`ifdef ROMIX_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
